inverse_sweep_ctrl: RTL
=======================

Name: inverse_sweep_ctrl

Overview:
Frame-level scheduler for the per-frequency inverse core (8 mics x 2 sources, 257 bins). One frame_start request makes the block issue one core_start pulse per frequency bin, in order. Before it advances, it waits for the core's done, enforces a configurable inter-start gap and a per-bin timeout, and cross-checks the core's all_freq_finish at the last bin. It sits between the system sequencer and the inverse core's start/done/all_freq_finish pins.

Parameters:
FREQ_NUM, 257, frequency bins per frame
FREQ_WIDTH, 9, width of freq_idx; must satisfy 2^FREQ_WIDTH >= FREQ_NUM
TIMEOUT_CYCLES, 4096, maximum WAIT cycles per bin before timeout (>=2)
TO_WIDTH, 13, width of the timeout counter; must hold TIMEOUT_CYCLES
GAP_CYCLES, 2, idle cycles between a core_done and the next core_start (0 allowed)
FRAME_CNT_WIDTH, 16, width of the completed-frame counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
frame_start  in  1  one-cycle request to sweep all bins
abort  in  1  synchronous abort of the current frame
err_clr  in  1  clears sticky error flags
core_done  in  1  inverse core done for the current bin
core_all_freq_finish  in  1  inverse core end-of-sweep flag
core_start  out  1  one-cycle start pulse to the core
freq_idx  out  FREQ_WIDTH  bin currently being processed
busy  out  1  high from the first core_start cycle until frame end
frame_done  out  1  one-cycle pulse on clean frame completion
frame_cnt  out  FRAME_CNT_WIDTH  completed frames, wraps modulo 2^FRAME_CNT_WIDTH
timeout_err  out  1  sticky: a bin exceeded TIMEOUT_CYCLES
sync_err  out  1  sticky: core_all_freq_finish disagreed at the last bin
overrun_err  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All outputs are 0: core_start, freq_idx, busy, frame_done, frame_cnt, timeout_err, sync_err, overrun_err. Reset mid-frame abandons the frame with no frame_done. All outputs are registered.
- States: IDLE, START, WAIT, GAP, DONE.
- IDLE: frame_start=1 -> START; freq_idx <= 0.
- START (1 cycle): core_start=1, busy=1; timeout counter <= 0; next state WAIT. core_done is ignored in START.
- WAIT: counter increments each cycle.
  - core_done=1 and freq_idx != FREQ_NUM-1: if GAP_CYCLES=0, go to START with freq_idx+1; otherwise go to GAP.
  - core_done=1 and freq_idx == FREQ_NUM-1: sample core_all_freq_finish in the same cycle; if it is 0, set sync_err. Go to DONE.
  - No core_done and counter == TIMEOUT_CYCLES-1: set timeout_err and go to IDLE. No frame_done is issued and frame_cnt is unchanged.
  - core_done and timeout in the same cycle: core_done wins.
- GAP: waits GAP_CYCLES cycles, then goes to START with freq_idx incremented. busy stays 1.
- DONE (1 cycle): frame_done=1, frame_cnt+1; next state IDLE; busy=0 from the DONE cycle onward. freq_idx holds its value until the next frame_start.
- Timing:
  - frame_start sampled at edge T -> core_start high during cycle T+1.
  - core_done sampled at edge D -> next core_start high during cycle D+1+GAP_CYCLES.
  - Last-bin core_done at edge D -> frame_done high during cycle D+1.
- core_start is never high on two consecutive cycles.
- frame_start while not IDLE is ignored and sets overrun_err. frame_start in the DONE cycle also counts as an overrun.
- abort=1 in any non-IDLE state: IDLE next cycle, freq_idx <= 0, no frame_done, no error flag. abort has priority over core_done, timeout and frame_start in the same cycle.
- err_clr clears all three sticky flags. A flag set in the same cycle as err_clr stays set (set wins).
- A core_done outside WAIT is ignored.

Test Plan:
- FREQ_NUM=4, GAP_CYCLES=2, core_done 5 cycles after each core_start, all_freq_finish=1 at the last done -> exactly 4 core_start pulses with freq_idx 0,1,2,3, each start 3 cycles after the prior done; frame_done once; frame_cnt=1; no errors.
- Default params, core model with 2-cycle read latency processing 16 samples per bin, 2 back-to-back frames -> 257 starts per frame, frame_cnt=2, final freq_idx=256.
- FREQ_NUM=4, core_done withheld on bin 2, TIMEOUT_CYCLES=8 -> timeout_err=1 exactly 8 cycles after WAIT entry; busy=0 the next cycle; frame_done never asserted; err_clr clears timeout_err.
- Last-bin done with core_all_freq_finish=0 -> sync_err=1, frame_done still pulses, frame_cnt increments.
- Extra frame_start during bin 1, and abort together with core_done on bin 2 -> overrun_err=1; abort wins: IDLE, freq_idx=0, no further core_start, frame_cnt unchanged.
- rst_n low for 1 cycle during WAIT on bin 3 -> all outputs 0 next cycle; a fresh frame_start then restarts at freq_idx=0.

Source files
------------

// File: rtl/inverse_sweep_ctrl.sv
// inverse_sweep_ctrl: frame-level scheduler for the per-frequency inverse core.
// One frame_start sweeps every frequency bin in order, issuing one core_start
// per bin, waiting for core_done, inserting an idle gap between bins, guarding
// each bin with a timeout and cross-checking core_all_freq_finish at the end.
module inverse_sweep_ctrl #(
  parameter int FREQ_NUM        = 257,
  parameter int FREQ_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int TO_WIDTH        = 13,
  parameter int GAP_CYCLES      = 2,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic                       abort,
  input  logic                       err_clr,
  input  logic                       core_done,
  input  logic                       core_all_freq_finish,
  output logic                       core_start,
  output logic [FREQ_WIDTH-1:0]      freq_idx,
  output logic                       busy,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       timeout_err,
  output logic                       sync_err,
  output logic                       overrun_err
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [FREQ_WIDTH-1:0] LAST_IDX = FREQ_WIDTH'(FREQ_NUM - 1);
  localparam logic [TO_WIDTH-1:0]   TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [FREQ_WIDTH-1:0]      freq_idx_q, freq_idx_d;
  logic [TO_WIDTH-1:0]        to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       core_start_q, core_start_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;
  logic                       timeout_err_q, timeout_err_d;
  logic                       sync_err_q, sync_err_d;
  logic                       overrun_err_q, overrun_err_d;

  logic abort_act;
  logic last_bin;
  logic to_hit;
  logic timeout_set, sync_set, overrun_set;

  // Abort only matters once a frame is under way; it overrides every other event.
  assign abort_act   = abort && (state_q != S_IDLE);
  assign last_bin    = (freq_idx_q == LAST_IDX);
  assign to_hit      = (to_cnt_q == TO_LAST);
  assign timeout_set = (state_q == S_WAIT) && !core_done && to_hit && !abort_act;
  assign sync_set    = (state_q == S_WAIT) && core_done && last_bin &&
                       !core_all_freq_finish && !abort_act;
  assign overrun_set = frame_start && (state_q != S_IDLE) && !abort_act;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; core_done beats a same-cycle timeout, abort beats all.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (frame_start) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          if (last_bin)             state_d = S_DONE;
          else if (GAP_CYCLES == 0) state_d = S_START;
          else                      state_d = S_GAP;
        end else if (to_hit) begin
          state_d = S_IDLE;
        end
      end
      S_GAP:   if (gap_cnt_q == GAP_LAST) state_d = S_START;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_act) state_d = S_IDLE;
  end

  // Output/datapath next values, derived from the upcoming state so every output is a flop.
  always_comb begin
    core_start_d = (state_d == S_START);
    busy_d       = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_GAP);
    frame_done_d = (state_d == S_DONE);

    freq_idx_d = freq_idx_q;
    if (abort_act)
      freq_idx_d = '0;
    else if ((state_q == S_IDLE) && frame_start)
      freq_idx_d = '0;
    else if ((state_d == S_START) && (state_q != S_IDLE))
      freq_idx_d = freq_idx_q + 1'b1;

    to_cnt_d = to_cnt_q;
    if (state_d == S_START)      to_cnt_d = '0;
    else if (state_q == S_WAIT)  to_cnt_d = to_cnt_q + 1'b1;

    gap_cnt_d = '0;
    if (state_q == S_GAP) gap_cnt_d = gap_cnt_q + 1'b1;

    frame_cnt_d = frame_cnt_q;
    if ((state_d == S_DONE) && (state_q == S_WAIT)) frame_cnt_d = frame_cnt_q + 1'b1;

    timeout_err_d = (timeout_err_q && !err_clr) || timeout_set;
    sync_err_d    = (sync_err_q    && !err_clr) || sync_set;
    overrun_err_d = (overrun_err_q && !err_clr) || overrun_set;
  end

  // Output and datapath registers; reset clears everything, abandoning any frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      freq_idx_q    <= '0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      sync_err_q    <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      core_start_q  <= core_start_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      freq_idx_q    <= freq_idx_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      sync_err_q    <= sync_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign core_start  = core_start_q;
  assign freq_idx    = freq_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;
  assign sync_err    = sync_err_q;
  assign overrun_err = overrun_err_q;

endmodule
